ones_counter: RTL and testbench

Sequential bit-counting stage that counts the number of 1 bits in a captured data word and presents the count as a 4-bit value. It sits directly upstream of the board's hex display decoder: `result` drives the decoder's 4-bit value input. Switches, or a parent controller, drive `data_in` and `start`. The block is a three-state controller plus a right-shift datapath with a one-bit-per-cycle accumulator.

---
 rtl/ones_counter.sv | 114 +++++++++++
 tb/tb_ones_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ones_counter.sv
// ones_counter
//   Counts the 1 bits of a captured data word, one bit per clock, and
//   presents the running count as a 4-bit value for a hex display decoder.
//   A three-state controller (IDLE/COUNT/DONE) drives a right-shift register
//   and a 4-bit accumulator.
//
// Parameters
//   WIDTH    data word width, 1..15 (count always fits in 4 bits)
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   start    level request; sampled only in IDLE and DONE
//   data_in  word to count; captured on the accepting edge in IDLE
//   result   number of 1s counted so far / final count
//   done     high while in DONE
//   busy     high while in COUNT
//
// Build option
//   ONES_COUNTER_EARLY_EXIT_EN: when defined, COUNT ends as soon as the
//   remaining shift-register contents are zero, so latency depends on the
//   highest set bit. When undefined, COUNT always lasts WIDTH cycles.
//   The final result is the same in both builds.

module ones_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [3:0]       result,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic             last;

`ifdef ONES_COUNTER_EARLY_EXIT_EN
    // Stop once no set bits remain beyond the one being added this cycle.
    assign last = ((a >> 1) == '0);
`else
    localparam int unsigned KW = $clog2(WIDTH) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    logic [KW-1:0] k;

    assign last = (k == K_LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COUNT;
            COUNT:   if (last)  state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: result is only cleared by reset or an accepting edge, so the
    // display keeps the last count through DONE and IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a      <= '0;
            result <= '0;
`ifndef ONES_COUNTER_EARLY_EXIT_EN
            k      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a      <= data_in;
                        result <= '0;
`ifndef ONES_COUNTER_EARLY_EXIT_EN
                        k      <= '0;
`endif
                    end
                end
                COUNT: begin
                    result <= result + 4'(a[0]);
                    a      <= a >> 1;
`ifndef ONES_COUNTER_EARLY_EXIT_EN
                    k      <= k + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Pure decodes of the state register.
    assign done = (state == DONE);
    assign busy = (state == COUNT);

endmodule

// File: tb/tb_ones_counter.sv
module tb_ones_counter;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] result;
    logic       done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    ones_counter #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         exp_result;
        int         lat_full;
        int         lat_early;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef ONES_COUNTER_EARLY_EXIT_EN
        return v.lat_early;
`else
        return v.lat_full;
`endif
    endfunction

    // One pulsed request: start high for the accepting edge only.
    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        int  busy_bad;
        int  mono_bad;
        logic [3:0] prev;
        @(negedge clk);
        data_in = v.data;
        start   = 1'b1;
        @(posedge clk);              // E0
        #1;
        start = 1'b0;
        busy_bad = (busy !== 1'b1) ? 1 : 0;
        mono_bad = 0;
        prev     = result;
        n        = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_bad++;
            if (result < prev) mono_bad++;
            prev = result;
        end
        chk($sformatf("v%0d latency", idx), n, exp_lat(v));
        chk($sformatf("v%0d result", idx), int'(result), v.exp_result);
        chk($sformatf("v%0d busy_in_count", idx), busy_bad, 0);
        chk($sformatf("v%0d monotonic", idx), mono_bad, 0);
        chk($sformatf("v%0d busy_at_done", idx), int'(busy), 0);
        @(posedge clk);              // DONE -> IDLE with start low
        #1;
        chk($sformatf("v%0d idle_done", idx), int'(done), 0);
        chk($sformatf("v%0d idle_busy", idx), int'(busy), 0);
        chk($sformatf("v%0d idle_result_hold", idx), int'(result), v.exp_result);
    endtask

    initial begin
        int rises;
        int first_done;
        logic prev_busy;
        vec_t v81;

        vecs[0] = '{8'b1011_0110, 5, 8, 8};
        vecs[1] = '{8'hFF,        8, 8, 8};
        vecs[2] = '{8'h00,        0, 8, 1};
        vecs[3] = '{8'h01,        1, 8, 1};
        vecs[4] = '{8'h80,        1, 8, 8};
        vecs[5] = '{8'h0F,        4, 8, 4};
        vecs[6] = '{8'h2A,        3, 8, 6};
        vecs[7] = '{8'h10,        1, 8, 5};
        vecs[8] = '{8'h81,        2, 8, 8};

        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", int'(result), 0);
        chk("reset done", int'(done), 0);
        chk("reset busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Asynchronous reset between edges with a nonzero held result.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset result", int'(result), 0);
        chk("async_reset done", int'(done), 0);
        chk("async_reset busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // start held for 30 cycles; data_in changes during COUNT.
        @(negedge clk);
        data_in    = 8'h0F;
        start      = 1'b1;
        rises      = 0;
        first_done = -1;
        prev_busy  = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy !== 1'b1) rises++;
            prev_busy = busy;
            if (done === 1'b1 && first_done < 0) first_done = c;
            if (c == 3) data_in = 8'hFF;
        end
        chk("hold single_count", rises, 1);
        chk("hold done_latency", first_done, exp_lat(vecs[5]) + 1);
        chk("hold done_held", int'(done), 1);
        chk("hold result", int'(result), 4);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("hold idle_done", int'(done), 0);
        chk("hold idle_busy", int'(busy), 0);
        chk("hold idle_result", int'(result), 4);

        // Reset during the 4th COUNT cycle, then a fresh full count.
        @(negedge clk);
        data_in = 8'hFF;
        start   = 1'b1;
        @(posedge clk);              // E0
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midcount busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("midcount_reset result", int'(result), 0);
        chk("midcount_reset done", int'(done), 0);
        chk("midcount_reset busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("midcount_reset held result", int'(result), 0);
        @(negedge clk);
        reset = 1'b0;
        v81 = vecs[8];
        run_vec(v81, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
